pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_adder.sv | 13 +
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, increment and counter widths.
package pc_pkg;

    localparam int unsigned PC_INC = 4;
    localparam int unsigned FCNT_W = 3;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_t;

endpackage : pc_pkg

// File: rtl/pc_sequencer_if.sv
// Control/bus bundle between the core (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    import pc_pkg::*;

    logic              stall;
    logic              br_valid;
    logic              brch;
    logic [ADDR_W-1:0] br_target;
    logic              halt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              flush;
    logic              halted;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output stall, br_valid, brch, br_target, halt,
        input  pc, pc_plus4, flush, halted, taken_cnt
    );

    modport slave (
        input  stall, br_valid, brch, br_target, halt,
        output pc, pc_plus4, flush, halted, taken_cnt
    );

endinterface : pc_sequencer_if

// File: rtl/pc_adder.sv
// Fixed +4 incrementer, wrapping modulo 2^ADDR_W.
module pc_adder
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_a,
    output logic [ADDR_W-1:0] o_sum
);

    assign o_sum = i_a + ADDR_W'(PC_INC);

endmodule : pc_adder

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: linear fetch, branch redirect with timed flush window, halt, redirect counter.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned      FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    pc_state_t         r_state;
    pc_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic              r_flush;
    logic              r_halted;
    logic [CNT_W-1:0]  r_taken_cnt;
    logic [CNT_W-1:0]  w_taken_nxt;
    logic              w_redirect;
    logic              w_unused_tgt;

    pc_adder #(.ADDR_W(ADDR_W)) u_pc_adder (
        .i_a   (r_pc),
        .o_sum (w_pc_inc)
    );

    assign w_redirect   = bus.br_valid & bus.brch;
    assign w_unused_tgt = ^bus.br_target[1:0];

    // Next-state / next-PC decision; RUN priority is redirect > halt > stall > increment.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fcnt_nxt  = r_fcnt;
        w_taken_nxt = r_taken_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_redirect) begin
                    w_pc_nxt    = {bus.br_target[ADDR_W-1:2], 2'b00};
                    w_fcnt_nxt  = FCNT_W'(FLUSH_CYCLES);
                    w_state_nxt = ST_SQUASH;
                    if (r_taken_cnt != {CNT_W{1'b1}}) begin
                        w_taken_nxt = r_taken_cnt + CNT_W'(1);
                    end
                end else if (bus.halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (!bus.stall) begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            ST_SQUASH: begin
                // Branch/halt inputs here belong to squashed instructions.
                if (!bus.stall) begin
                    w_pc_nxt = w_pc_inc;
                end
                if (r_fcnt <= FCNT_W'(1)) begin
                    w_fcnt_nxt  = '0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fcnt_nxt = r_fcnt - FCNT_W'(1);
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_fcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_fcnt      <= '0;
            r_flush     <= 1'b0;
            r_halted    <= 1'b0;
            r_taken_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_fcnt      <= w_fcnt_nxt;
            r_flush     <= (w_state_nxt == ST_SQUASH);
            r_halted    <= (w_state_nxt == ST_HALTED);
            r_taken_cnt <= w_taken_nxt;
        end
    end

    assign bus.pc        = r_pc;
    assign bus.pc_plus4  = w_pc_inc;
    assign bus.flush     = r_flush;
    assign bus.halted    = r_halted;
    assign bus.taken_cnt = r_taken_cnt;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a cycle-level behavioural model.
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int unsigned AW       = 32;
    localparam int unsigned FLUSH_N  = 2;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;
    localparam int          N_RANDOM = 3000;

    logic clk = 1'b0;
    logic rst;
    logic rst_w;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(AW)) bus  ();
    pc_sequencer_if #(.ADDR_W(AW)) wbus ();

    pc_sequencer #(.ADDR_W(AW), .RESET_PC(32'h0), .FLUSH_CYCLES(FLUSH_N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pc_sequencer #(.ADDR_W(AW), .RESET_PC(WRAP_PC), .FLUSH_CYCLES(3)) u_wrap (
        .clk (clk),
        .rst (rst_w),
        .bus (wbus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: PC, remaining flush cycles, halted flag, redirect count.
    logic [31:0] m_pc;
    int          m_left;
    bit          m_halted;
    int          m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit s, input bit bv, input bit br,
                              input logic [31:0] tgt, input bit h);
        if (r) begin
            m_pc = 32'h0; m_left = 0; m_halted = 0; m_cnt = 0;
        end else if (m_halted) begin
            m_halted = 1;
        end else if (m_left > 0) begin
            m_left--;
            if (!s) m_pc = m_pc + 32'd4;
        end else if (bv && br) begin
            m_pc   = tgt & 32'hFFFF_FFFC;
            m_left = FLUSH_N;
            m_cnt  = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        end else if (h) begin
            m_halted = 1;
        end else if (!s) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all();
        check_eq("pc",        bus.pc,              m_pc);
        check_eq("pc_plus4",  bus.pc_plus4,        m_pc + 32'd4);
        check_eq("flush",     32'(bus.flush),      32'(m_left > 0));
        check_eq("halted",    32'(bus.halted),     32'(m_halted));
        check_eq("taken_cnt", 32'(bus.taken_cnt),  32'(m_cnt));
    endtask

    task automatic step(input bit r, input bit s, input bit bv, input bit br,
                        input logic [31:0] tgt, input bit h);
        rst           = r;
        bus.stall     = s;
        bus.br_valid  = bv;
        bus.brch      = br;
        bus.br_target = tgt;
        bus.halt      = h;
        @(posedge clk);
        model_step(r, s, bv, br, tgt, h);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        bus.stall = 0; bus.br_valid = 0; bus.brch = 0; bus.br_target = '0; bus.halt = 0;
        wbus.stall = 0; wbus.br_valid = 0; wbus.brch = 0; wbus.br_target = '0; wbus.halt = 0;
        m_pc = 32'h0; m_left = 0; m_halted = 0; m_cnt = 0;

        // Reset state, and wrap-around on the second instance.
        step(1, 0, 0, 0, 32'h0, 0);
        check_eq("rst_pc", bus.pc, 32'h0);
        check_eq("wrap_rst_pc", wbus.pc, WRAP_PC);
        check_eq("wrap_rst_plus4", wbus.pc_plus4, 32'hFFFF_FFFC);
        rst_w = 1'b0;
        step(0, 0, 0, 0, 32'h0, 0);
        check_eq("wrap_pc1", wbus.pc, 32'hFFFF_FFFC);
        check_eq("wrap_plus4_1", wbus.pc_plus4, 32'h0);
        step(0, 0, 0, 0, 32'h0, 0);
        check_eq("wrap_pc2", wbus.pc, 32'h0);

        // Linear fetch up to 0x20.
        idle(2);
        check_eq("lin_pc_10", bus.pc, 32'h10);
        idle(4);
        check_eq("lin_pc_20", bus.pc, 32'h20);

        // Taken branch: target low bits dropped, two flush cycles.
        step(0, 0, 1, 1, 32'h103, 0);
        check_eq("br_pc", bus.pc, 32'h100);
        check_eq("br_flush", 32'(bus.flush), 32'd1);
        check_eq("br_cnt", 32'(bus.taken_cnt), 32'd1);
        idle(1);
        check_eq("br_pc_104", bus.pc, 32'h104);
        check_eq("br_flush2", 32'(bus.flush), 32'd1);
        idle(1);
        check_eq("br_pc_108", bus.pc, 32'h108);
        check_eq("br_flush_end", 32'(bus.flush), 32'd0);

        // Not-taken branch does nothing special.
        step(0, 0, 1, 0, 32'h500, 0);
        check_eq("nt_pc", bus.pc, 32'h10C);

        // Branch then stalled squash with a branch inside the window.
        step(0, 0, 1, 1, 32'h103, 0);
        step(0, 1, 1, 1, 32'h200, 0);
        step(0, 1, 1, 1, 32'h300, 0);
        check_eq("sq_flush_off", 32'(bus.flush), 32'd0);
        step(0, 1, 0, 0, 32'h0, 0);
        check_eq("sq_pc_hold", bus.pc, 32'h100);
        check_eq("sq_cnt", 32'(bus.taken_cnt), 32'd2);

        // Reset in the middle of a squash window.
        step(0, 0, 1, 1, 32'h80, 0);
        step(1, 0, 0, 0, 32'h0, 0);
        check_eq("rst_sq_flush", 32'(bus.flush), 32'd0);

        // Halt at 0x40, ignore branches while halted, then reset out.
        idle(16);
        check_eq("halt_at", bus.pc, 32'h40);
        step(0, 0, 0, 0, 32'h0, 1);
        check_eq("halted_set", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 10; i++) step(0, i[0], 1, 1, $urandom, 1);
        check_eq("halt_pc_hold", bus.pc, 32'h40);
        step(1, 0, 0, 0, 32'h0, 0);
        check_eq("halt_rst_pc", bus.pc, 32'h0);
        check_eq("halt_rst_flag", 32'(bus.halted), 32'd0);

        // Saturation: preload the counter just below the top, then keep branching.
        force u_dut.r_taken_cnt = 16'hFFFD;
        m_cnt = 32'hFFFD;
        idle(1);
        release u_dut.r_taken_cnt;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 1, 32'h1000 + 32'(i * 16), 0);
            idle(FLUSH_N);
        end
        check_eq("sat_cnt", 32'(bus.taken_cnt), 32'hFFFF);
        step(1, 0, 0, 0, 32'h0, 0);

        // Randomized traffic.
        for (int i = 0; i < N_RANDOM; i++) begin
            step(($urandom_range(149) == 0),
                 ($urandom_range(3) == 0),
                 ($urandom_range(4) == 0),
                 1'($urandom_range(1)),
                 $urandom,
                 ($urandom_range(59) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pc_sequencer
